// File: rtl/bnn_pkg.sv
// Shared opcodes, response bytes and sequencer state type for the BNN command path.
package bnn_pkg;

    localparam logic [7:0] OP_LOAD   = 8'hA5;
    localparam logic [7:0] OP_RUN    = 8'h5A;
    localparam logic [7:0] OP_STATUS = 8'h3C;

    localparam logic [7:0] RSP_ACK = 8'hAC;
    localparam logic [7:0] RSP_NAK = 8'hEE;

    localparam logic [3:0] STATUS_TAG = 4'h5;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitDone,
        StSend
    } seq_state_t;

endpackage

// File: rtl/bnn_timeout_counter.sv
// Loadable idle-cycle down-counter; expired rises TIMEOUT cycles after the last load.
module bnn_timeout_counter #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    logic [CW-1:0] count_q;
    logic          armed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else if (load) begin
            count_q <= CW'(TIMEOUT - 1);
            armed_q <= 1'b1;
        end else if (clear) begin
            armed_q <= 1'b0;
        end else if (armed_q && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = armed_q && (count_q == '0);

endmodule

// File: rtl/bnn_cmd_sequencer.sv
// Parses UART command bytes, fills the BNN image buffer, runs inference and
// queues a single response byte per command to the UART transmitter.
module bnn_cmd_sequencer
    import bnn_pkg::*;
#(
    parameter int unsigned IMG_BYTES = 8,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [IMG_BYTES*8-1:0] bnn_img,
    output logic                   bnn_start,
    input  logic                   bnn_done,
    input  logic [3:0]             bnn_class,
    output logic                   busy
);

    localparam int unsigned CntW = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1;

    seq_state_t             state_q, state_d;
    logic [IMG_BYTES*8-1:0] img_q, img_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   loaded_q, loaded_d;
    logic                   overrun_q, overrun_d;
    logic                   tout_q, tout_d;
    logic [7:0]             rsp_q, rsp_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   bnn_start_q, bnn_start_d;
    logic                   tmr_load, tmr_clear, tmr_expired;

    bnn_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .clear   (tmr_clear),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        img_d       = img_q;
        cnt_d       = cnt_q;
        loaded_d    = loaded_q;
        overrun_d   = overrun_q;
        tout_d      = tout_q;
        rsp_d       = rsp_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        bnn_start_d = 1'b0;
        tmr_load    = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_LOAD: begin
                            state_d  = StLoad;
                            cnt_d    = '0;
                            loaded_d = 1'b0;
                            tmr_load = 1'b1;
                        end
                        OP_RUN: begin
                            if (loaded_q) begin
                                bnn_start_d = 1'b1;
                                state_d     = StWaitDone;
                                tmr_load    = 1'b1;
                            end else begin
                                rsp_d   = RSP_NAK;
                                state_d = StSend;
                            end
                        end
                        OP_STATUS: begin
                            rsp_d     = {STATUS_TAG, loaded_q, overrun_q, tout_q, 1'b0};
                            overrun_d = 1'b0;
                            tout_d    = 1'b0;
                            state_d   = StSend;
                        end
                        default: begin
                            rsp_d   = RSP_NAK;
                            state_d = StSend;
                        end
                    endcase
                end
            end
            StLoad: begin
                // Timeout takes priority over a byte arriving in the same cycle.
                if (tmr_expired) begin
                    tout_d   = 1'b1;
                    loaded_d = 1'b0;
                    rsp_d    = RSP_NAK;
                    state_d  = StSend;
                    if (rx_valid) begin
                        overrun_d = 1'b1;
                    end
                end else if (rx_valid) begin
                    img_d[8*int'(cnt_q) +: 8] = rx_data;
                    tmr_load = 1'b1;
                    if (cnt_q == CntW'(IMG_BYTES - 1)) begin
                        loaded_d = 1'b1;
                        rsp_d    = RSP_ACK;
                        state_d  = StSend;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWaitDone: begin
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (bnn_done) begin
                    rsp_d   = {4'h0, bnn_class};
                    state_d = StSend;
                end else if (tmr_expired) begin
                    tout_d   = 1'b1;
                    loaded_d = 1'b0;
                    rsp_d    = RSP_NAK;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = rsp_q;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        tmr_clear = (state_d != StLoad) && (state_d != StWaitDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            img_q       <= '0;
            cnt_q       <= '0;
            loaded_q    <= 1'b0;
            overrun_q   <= 1'b0;
            tout_q      <= 1'b0;
            rsp_q       <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            bnn_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            img_q       <= img_d;
            cnt_q       <= cnt_d;
            loaded_q    <= loaded_d;
            overrun_q   <= overrun_d;
            tout_q      <= tout_d;
            rsp_q       <= rsp_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            bnn_start_q <= bnn_start_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign bnn_start = bnn_start_q;
    assign bnn_img   = img_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bnn_cmd_sequencer.sv
// Scoreboard bench: expected response bytes are queued as commands are driven
// and popped when tx_start is observed.
module tb_bnn_cmd_sequencer;

    localparam int unsigned IMG_BYTES = 8;
    localparam int unsigned TIMEOUT   = 16;

    logic                   clk;
    logic                   rst;
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic [7:0]             tx_data;
    logic                   tx_start;
    logic                   tx_busy;
    logic [IMG_BYTES*8-1:0] bnn_img;
    logic                   bnn_start;
    logic                   bnn_done;
    logic [3:0]             bnn_class;
    logic                   busy;

    bnn_cmd_sequencer #(
        .IMG_BYTES (IMG_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .bnn_img   (bnn_img),
        .bnn_start (bnn_start),
        .bnn_done  (bnn_done),
        .bnn_class (bnn_class),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_count = 0;
    int tx_cyc = 0;
    int start_count = 0;
    int start_cyc = 0;
    int pushed = 0;
    int last_rx_cyc = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst && tx_start) begin
            tx_count++;
            tx_cyc = cyc;
            check("tx_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) check("tx_data", 64'(tx_data), 64'(exp_q.pop_front()));
        end
        if (rst && bnn_start) begin
            start_count++;
            start_cyc = cyc;
        end
    end

    task automatic expect_tx(input logic [7:0] b);
        exp_q.push_back(b);
        pushed++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        rx_valid    = 1'b1;
        last_rx_cyc = cyc;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("tx_wait", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_start(input int prev);
        int n = 0;
        while (start_count == prev && n < 10) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("bnn_start_seen", 64'(start_count), 64'(prev + 1));
    endtask

    task automatic pulse_done(input logic [3:0] cls);
        bnn_done  = 1'b1;
        bnn_class = cls;
        @(posedge clk);
        #1 bnn_done = 1'b0;
    endtask

    task automatic load_image(input logic [7:0] base);
        expect_tx(8'hAC);
        send_byte(8'hA5);
        for (int i = 0; i < int'(IMG_BYTES); i++) send_byte(base + 8'(i));
        wait_tx(20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int prev;
        int done_cyc;
        int j;
        logic [63:0] img_exp;

        rst = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_busy = 1'b0;
        bnn_done = 1'b0; bnn_class = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_start", 64'(tx_start), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_img", 64'(bnn_img), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // RUN without a loaded image
        expect_tx(8'hEE);
        send_byte(8'h5A);
        wait_tx(10);
        check("run_nak_latency", 64'(tx_cyc - last_rx_cyc), 64'(2));
        check("run_nak_no_start", 64'(start_count), 64'(0));

        // Unknown opcode
        expect_tx(8'hEE);
        send_byte(8'h11);
        wait_tx(10);

        // Image load
        load_image(8'h01);
        check("load_img", 64'(bnn_img), 64'h0807060504030201);
        check("load_ack_latency", 64'(tx_cyc - last_rx_cyc), 64'(2));
        repeat (2) @(posedge clk);
        #1;
        check("load_busy_low", 64'(busy), 64'(0));

        // Inference with class 7
        prev = start_count;
        expect_tx(8'h07);
        send_byte(8'h5A);
        wait_start(prev);
        check("start_latency", 64'(start_cyc - last_rx_cyc), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        done_cyc = cyc;
        pulse_done(4'd7);
        wait_tx(10);
        check("start_once", 64'(start_count), 64'(prev + 1));
        check("result_latency", 64'(tx_cyc - done_cyc), 64'(2));

        // Timeout mid-load
        expect_tx(8'hEE);
        send_byte(8'hA5);
        for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i));
        wait_tx(TIMEOUT + 10);
        check("timeout_latency", 64'(tx_cyc - last_rx_cyc), 64'(TIMEOUT + 2));
        expect_tx(8'h52);
        send_byte(8'h3C);
        wait_tx(10);
        expect_tx(8'h50);
        send_byte(8'h3C);
        wait_tx(10);

        // Bytes dropped during WAIT_DONE
        load_image(8'h10);
        img_exp = 64'h1716151413121110;
        check("reload_img", 64'(bnn_img), img_exp);
        prev = start_count;
        expect_tx(8'h03);
        send_byte(8'h5A);
        wait_start(prev);
        for (int i = 0; i < 3; i++) send_byte(8'hF0 + 8'(i));
        pulse_done(4'd3);
        wait_tx(10);
        check("overrun_img_kept", 64'(bnn_img), img_exp);
        expect_tx(8'h5C);
        send_byte(8'h3C);
        wait_tx(10);

        // Transmitter held busy
        tx_busy = 1'b1;
        prev = tx_count;
        expect_tx(8'h58);
        send_byte(8'h3C);
        repeat (50) @(posedge clk);
        #1;
        check("busy_hold_pending", 64'(exp_q.size()), 64'(1));
        check("busy_hold_no_tx", 64'(tx_count), 64'(prev));
        tx_busy = 1'b0;
        j = cyc;
        wait_tx(10);
        check("busy_release_cycle", 64'(tx_cyc), 64'(j + 1));

        // Asynchronous reset mid-load
        send_byte(8'hA5);
        send_byte(8'h99);
        send_byte(8'h98);
        #2 rst = 1'b0;
        #1;
        check("arst_tx_data", 64'(tx_data), 64'(0));
        check("arst_tx_start", 64'(tx_start), 64'(0));
        check("arst_bnn_start", 64'(bnn_start), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_img", 64'(bnn_img), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        expect_tx(8'hEE);
        send_byte(8'h5A);
        wait_tx(10);

        check("tx_total", 64'(tx_count), 64'(pushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
